// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// State encoding, winner IDs and the latency counter type.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic WIN_IF = 1'b0;
  localparam logic WIN_D  = 1'b1;

  localparam int STARVE_W = 4;

  typedef logic [2:0] wcnt_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side bus of the fetch/data port arbiter.
// master drives requests and read data; slave is the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata,
    output if_rdata, if_ready,
    output d_rdata, d_ready,
    output mem_en, mem_we,
    output mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata,
    input  if_rdata, if_ready,
    input  d_rdata, d_ready,
    input  mem_en, mem_we,
    input  mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of data grants taken while fetch waits.
// o_starved tells the arbiter to let fetch win next.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_grant,
  input  logic i_win_d,
  input  logic i_if_req,
  output logic o_starved
);

  localparam logic [STARVE_W-1:0] MAX =
    STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_grant) begin
      if (i_win_d && i_if_req) begin
        if (r_cnt != '1)
          r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_starved = (r_cnt >= MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory between fetch and data ports.
// Data has priority; a starvation counter forces fetch through.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus,
  output logic              busy,
  output logic [31:0]       conflict_cycles
);

  localparam wcnt_t LAT_M1 = wcnt_t'(MEM_LAT - 1);

  arb_state_e        r_state;
  logic              r_win;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  wcnt_t             r_wcnt;
  logic              r_mem_en;
  logic              r_if_ready;
  logic              r_d_ready;
  logic              r_busy;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic [31:0]       r_conf;

  logic w_any;
  logic w_both;
  logic w_starved;
  logic w_win_d;
  logic w_grant;

  assign w_any   = bus.if_req | bus.d_req;
  assign w_both  = bus.if_req & bus.d_req;
  assign w_win_d = bus.d_req &
                   ~(bus.if_req & w_starved);
  assign w_grant = (r_state == IDLE) & w_any;

  mem_arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .i_grant   (w_grant),
    .i_win_d   (w_win_d),
    .i_if_req  (bus.if_req),
    .o_starved (w_starved)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_win      <= WIN_IF;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wcnt     <= '0;
      r_mem_en   <= 1'b0;
      r_if_ready <= 1'b0;
      r_d_ready  <= 1'b0;
      r_busy     <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_conf     <= '0;
    end else begin
      r_mem_en   <= 1'b0;
      r_if_ready <= 1'b0;
      r_d_ready  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_both)
            r_conf <= r_conf + 32'd1;
          if (w_any) begin
            r_win    <= w_win_d ? WIN_D : WIN_IF;
            r_we     <= w_win_d & bus.d_we;
            r_addr   <= w_win_d ? bus.d_addr
                                : bus.if_addr;
            if (w_win_d)
              r_wdata <= bus.d_wdata;
            r_mem_en <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          r_wcnt <= LAT_M1;
          if (r_we) begin
            r_if_ready <= (r_win == WIN_IF);
            r_d_ready  <= (r_win == WIN_D);
            r_state    <= RESP;
          end else begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          // last WAIT cycle is exactly MEM_LAT after ISSUE
          if (r_wcnt == '0) begin
            if (r_win == WIN_D)
              r_d_rdata <= bus.mem_rdata;
            else
              r_if_rdata <= bus.mem_rdata;
            r_if_ready <= (r_win == WIN_IF);
            r_d_ready  <= (r_win == WIN_D);
            r_state    <= RESP;
          end else begin
            r_wcnt <= r_wcnt - 1'b1;
          end
        end
        RESP: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.if_rdata  = r_if_rdata;
  assign bus.if_ready  = r_if_ready;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.d_ready   = r_d_ready;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign busy            = r_busy;
  assign conflict_cycles = r_conf;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed table, corner sequences,
// latency sweep and random traffic against a transaction model.
module tb_mem_port_arbiter;

  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst;
  logic init_mem;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus7 ();

  logic        busy, busy1, busy7;
  logic [31:0] conf, conf1, conf7;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32),
    .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .busy(busy), .conflict_cycles(conf)
  );

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32),
    .MEM_LAT(1), .STARVE_MAX(SMAX)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave),
    .busy(busy1), .conflict_cycles(conf1)
  );

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32),
    .MEM_LAT(7), .STARVE_MAX(SMAX)
  ) dut7 (
    .clk(clk), .rst(rst), .bus(bus7.slave),
    .busy(busy7), .conflict_cycles(conf7)
  );

  function automatic logic [31:0] memf(input int i);
    logic [7:0] b;
    b = i[7:0];
    return (i == 16) ? 32'hDEADBEEF
                     : {b, 8'hC3, ~b, 8'h3C};
  endfunction

  // Main memory: read data is valid only MEM_LAT cycles after issue.
  logic [31:0] env_mem [256];
  logic [31:0] rd_q;
  int          rd_cnt = 0;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++)
        env_mem[i] <= memf(i);
    end else if (bus.mem_en && bus.mem_we) begin
      env_mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
    if (bus.mem_en && !bus.mem_we) begin
      rd_q   <= env_mem[bus.mem_addr[9:2]];
      rd_cnt <= 1;
    end else if (rd_cnt != 0 && rd_cnt < 100) begin
      rd_cnt <= rd_cnt + 1;
    end
  end

  assign bus.mem_rdata = (rd_cnt == LAT) ? rd_q
                       : (32'hBAD00000 | 32'(rd_cnt));

  logic [31:0] a1, a7;
  int          c1 = 0, c7 = 0;

  always @(posedge clk) begin
    if (bus1.mem_en) begin
      a1 <= bus1.mem_addr; c1 <= 1;
    end else if (c1 != 0 && c1 < 100) begin
      c1 <= c1 + 1;
    end
    if (bus7.mem_en) begin
      a7 <= bus7.mem_addr; c7 <= 1;
    end else if (c7 != 0 && c7 < 100) begin
      c7 <= c7 + 1;
    end
  end

  assign bus1.mem_rdata = (c1 == 1) ? (a1 ^ 32'hCAFE0000)
                                    : 32'h0BADBAD1;
  assign bus7.mem_rdata = (c7 == 7) ? (a7 ^ 32'hCAFE0000)
                                    : 32'h0BADBAD7;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          rdy;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt[6];

  task automatic run_vec(input vec_t v);
    int seen;
    seen = -1;
    @(negedge clk);
    if (v.port == 1'b0) begin
      bus.if_req  = 1'b1;
      bus.if_addr = v.addr;
    end else begin
      bus.d_req   = 1'b1;
      bus.d_we    = v.we;
      bus.d_addr  = v.addr;
      bus.d_wdata = v.wdata;
    end
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("vec_mem_en", bus.mem_en, 1);
        chk("vec_mem_addr", bus.mem_addr, v.addr);
        chk("vec_mem_we", bus.mem_we, v.we);
        if (v.we)
          chk("vec_mem_wdata", bus.mem_wdata, v.wdata);
      end
      if (bus.if_ready || bus.d_ready) begin
        if (seen < 0) seen = c;
        chk("vec_ready_port",
            {bus.if_ready, bus.d_ready},
            v.port ? 2'b01 : 2'b10);
        chk("vec_rdata",
            v.port ? bus.d_rdata : bus.if_rdata,
            v.rdata);
      end
      bus.if_req = 1'b0;
      bus.d_req  = 1'b0;
    end
    chk("vec_ready_cycle", seen, v.rdy);
  endtask

  // Random-phase reference state
  logic [31:0] ref_mem [256];
  int          free_at, iss_at, rdy_at, starve, rconf;
  bit          act, g_d, g_we;
  logic [31:0] g_addr, g_wd, g_rd;
  bit          pif, pd, ifdrop, ddrop, rq_if, rq_d;
  logic [31:0] ref_ifrd, ref_drd;

  int ifr, dr, n;
  int seq[6];
  int exp_seq[6];
  int r1, r7;

  initial begin
    rst = 1'b1;
    init_mem = 1'b1;
    bus.if_req = 0; bus.if_addr = 0;
    bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = 0; bus.d_wdata = 0;
    bus1.if_req = 0; bus1.if_addr = 0;
    bus1.d_req = 0; bus1.d_we = 0;
    bus1.d_addr = 0; bus1.d_wdata = 0;
    bus7.if_req = 0; bus7.if_addr = 0;
    bus7.d_req = 0; bus7.d_we = 0;
    bus7.d_addr = 0; bus7.d_wdata = 0;

    vt[0] = '{1'b0, 1'b0, 32'h40, 32'h0,
              4, 32'hDEADBEEF};
    vt[1] = '{1'b1, 1'b1, 32'h100, 32'h12345678,
              2, 32'h0};
    vt[2] = '{1'b1, 1'b0, 32'h100, 32'h0,
              4, 32'h12345678};
    vt[3] = '{1'b0, 1'b0, 32'h100, 32'h0,
              4, 32'h12345678};
    vt[4] = '{1'b1, 1'b1, 32'h40, 32'hA5A5A5A5,
              2, 32'h12345678};
    vt[5] = '{1'b0, 1'b0, 32'h40, 32'h0,
              4, 32'hA5A5A5A5};
    exp_seq = '{1, 1, 1, 1, 0, 1};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_if_ready", bus.if_ready, 0);
    chk("rst_d_ready", bus.d_ready, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_if_rdata", bus.if_rdata, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_conflicts", conf, 0);
    rst = 1'b0;
    init_mem = 1'b0;

    for (int i = 0; i < 6; i++)
      run_vec(vt[i]);

    // Both request together: data first, then fetch.
    do_reset();
    @(negedge clk);
    bus.if_req = 1; bus.if_addr = 32'h40;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h100;
    ifr = -1; dr = -1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.d_ready && dr < 0) begin
        dr = c;
        chk("prio_d_rdata", bus.d_rdata, 32'h12345678);
      end
      if (bus.if_ready && ifr < 0) begin
        ifr = c;
        chk("prio_if_rdata", bus.if_rdata, 32'hA5A5A5A5);
        bus.if_req = 0;
      end
      bus.d_req = 0;
    end
    chk("prio_d_cycle", dr, 4);
    chk("prio_if_cycle", ifr, 9);
    chk("prio_conflicts", conf, 1);

    // Fetch held while data re-requests every IDLE cycle.
    do_reset();
    @(negedge clk);
    bus.if_req = 1; bus.if_addr = 32'h40;
    bus.d_req = 1; bus.d_we = 1;
    bus.d_addr = 32'h200; bus.d_wdata = 32'h0;
    n = 0;
    for (int c = 1; c < 60 && n < 6; c++) begin
      @(negedge clk);
      if (bus.d_ready && n < 6) begin
        seq[n] = 1; n++;
      end
      if (bus.if_ready && n < 6) begin
        seq[n] = 0; n++;
      end
      bus.d_wdata = 32'(c);
      if (n == 6) begin
        bus.if_req = 0; bus.d_req = 0;
      end
    end
    bus.if_req = 0; bus.d_req = 0;
    chk("starve_count", n, 6);
    for (int i = 0; i < 6; i++)
      if (i < n)
        chk("starve_seq", seq[i], exp_seq[i]);
    repeat (3) @(negedge clk);
    chk("starve_conflicts", conf, 6);

    // Reset during WAIT of a read abandons it.
    do_reset();
    @(negedge clk);
    bus.if_req = 1; bus.if_addr = 32'h40;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h100;
    @(negedge clk);
    bus.if_req = 0; bus.d_req = 0;
    @(negedge clk);
    chk("midrst_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_mem_en", bus.mem_en, 0);
    chk("midrst_conflicts", conf, 0);
    n = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.if_ready || bus.d_ready) n++;
      @(negedge clk);
    end
    chk("midrst_no_ready", n, 0);
    chk("midrst_idle", busy, 0);

    // Latency sweep: MEM_LAT=1 and MEM_LAT=7.
    @(negedge clk);
    bus1.if_req = 1; bus1.if_addr = 32'h80;
    bus7.if_req = 1; bus7.if_addr = 32'h84;
    r1 = -1; r7 = -1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (bus1.if_ready && r1 < 0) begin
        r1 = c;
        chk("lat1_rdata", bus1.if_rdata, 32'hCAFE0080);
      end
      if (bus7.if_ready && r7 < 0) begin
        r7 = c;
        chk("lat7_rdata", bus7.if_rdata, 32'hCAFE0084);
      end
      bus1.if_req = 0; bus7.if_req = 0;
    end
    chk("lat1_cycle", r1, 3);
    chk("lat7_cycle", r7, 9);
    chk("lat_idle", {busy1, busy7}, 0);
    chk("lat_conflicts", conf1 | conf7, 0);

    // Random traffic against a transaction-level model.
    @(negedge clk);
    init_mem = 1'b1;
    @(negedge clk);
    init_mem = 1'b0;
    for (int i = 0; i < 256; i++)
      ref_mem[i] = memf(i);
    do_reset();
    free_at = 0; act = 0; starve = 0; rconf = 0;
    pif = 0; pd = 0; ifdrop = 0; ddrop = 0;
    ref_ifrd = 0; ref_drd = 0;
    iss_at = -1; rdy_at = -1;
    g_d = 0; g_we = 0; g_addr = 0; g_wd = 0; g_rd = 0;
    for (int k = 0; k < 2500; k++) begin
      @(negedge clk);
      chk("rnd_if_ready", bus.if_ready,
          act && !g_d && k == rdy_at);
      chk("rnd_d_ready", bus.d_ready,
          act && g_d && k == rdy_at);
      chk("rnd_mem_en", bus.mem_en, act && k == iss_at);
      if (act && k == iss_at) begin
        chk("rnd_mem_addr", bus.mem_addr, g_addr);
        chk("rnd_mem_we", bus.mem_we, g_we);
        if (g_we)
          chk("rnd_mem_wdata", bus.mem_wdata, g_wd);
      end
      chk("rnd_busy", busy,
          act && k >= iss_at && k <= rdy_at);
      if (act && k == rdy_at) begin
        if (!g_we) begin
          if (g_d) ref_drd = g_rd;
          else     ref_ifrd = g_rd;
        end
        if (g_d) pd = 0;
        else     pif = 0;
        act = 0;
      end
      chk("rnd_if_rdata", bus.if_rdata, ref_ifrd);
      chk("rnd_d_rdata", bus.d_rdata, ref_drd);
      chk("rnd_conflicts", conf, rconf);

      if (!pif && $urandom_range(2) == 0) begin
        pif = 1; ifdrop = 0;
        bus.if_addr = $urandom;
      end
      if (!pd && $urandom_range(2) == 0) begin
        pd = 1; ddrop = 0;
        bus.d_we    = 1'($urandom_range(1));
        bus.d_addr  = $urandom;
        bus.d_wdata = $urandom;
      end
      if (act && !g_d && $urandom_range(3) == 0) begin
        bus.if_addr = $urandom;
        ifdrop = 1'($urandom_range(1));
      end
      if (act && g_d && $urandom_range(3) == 0) begin
        bus.d_addr  = $urandom;
        bus.d_wdata = $urandom;
        bus.d_we    = 1'($urandom_range(1));
        ddrop = 1'($urandom_range(1));
      end
      rq_if = pif && !ifdrop;
      rq_d  = pd && !ddrop;
      bus.if_req = rq_if;
      bus.d_req  = rq_d;

      if (!act && k >= free_at) begin
        if (rq_if && rq_d) rconf++;
        if (rq_if || rq_d) begin
          g_d = rq_d && !(rq_if && starve >= SMAX);
          if (g_d) begin
            g_we = bus.d_we; g_addr = bus.d_addr;
            g_wd = bus.d_wdata;
            starve = rq_if ? ((starve < 15) ? starve + 1 : 15)
                           : 0;
          end else begin
            g_we = 0; g_addr = bus.if_addr;
            starve = 0;
          end
          g_rd = ref_mem[g_addr[9:2]];
          if (g_we) ref_mem[g_addr[9:2]] = g_wd;
          act = 1;
          iss_at = k + 1;
          rdy_at = g_we ? k + 2 : k + 2 + LAT;
          free_at = rdy_at + 1;
        end
      end
    end
    bus.if_req = 0; bus.d_req = 0;

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
